// File: rtl/frame_painter.sv
// Frame painter: clears the VGA frame buffer, handshakes with the snake stream, paints its pixels.
// Optional FRAME_PAINTER_OFFSCREEN_EN adds a sticky `offscreen` flag for out-of-range pixels.
module frame_painter #(
    parameter int          WIDTH      = 640,
    parameter int          HEIGHT     = 480,
    parameter logic [2:0]  BG_COLOR   = 3'b000,
    parameter logic [2:0]  FG_COLOR   = 3'b010,
    parameter int          MAX_PIXELS = 3200
) (
    input  logic       draw_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] rx,
    input  logic [8:0] ry,
    input  logic       write_done,
    output logic       cleared,
    output logic [9:0] vga_x,
    output logic [8:0] vga_y,
    output logic [2:0] vga_color,
    output logic       vga_write,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       timeout
`ifdef FRAME_PAINTER_OFFSCREEN_EN
    ,
    output logic       offscreen
`endif
);

    // state  | meaning
    // IDLE   | waiting for frame_tick or a pended request
    // CLEAR  | raster sweep writing BG_COLOR, one pixel per cycle
    // NOTIFY | cleared pulse to the snake, no write
    // SETTLE | snake restarting, rx/ry not yet valid
    // PAINT  | writing streamed pixels until write_done or watchdog
    // DONE   | frame_done pulse, back to IDLE
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        NOTIFY = 3'd2,
        SETTLE = 3'd3,
        PAINT  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int              WD_W   = $clog2(MAX_PIXELS + 1);
    localparam logic [9:0]      X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0]      Y_LAST = 9'(HEIGHT - 1);
    localparam logic [10:0]     X_LIM  = 11'(WIDTH);
    localparam logic [9:0]      Y_LIM  = 10'(HEIGHT);
    localparam logic [WD_W-1:0] WD_TC  = WD_W'(MAX_PIXELS);

    state_t          state, state_nxt;
    logic            pending, pending_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;

    logic       cleared_nxt;
    logic [9:0] x_nxt;
    logic [8:0] y_nxt;
    logic [2:0] color_nxt;
    logic       write_nxt;
    logic       busy_nxt;
    logic       frame_done_nxt;
    logic       overrun_nxt;
    logic       timeout_nxt;
    logic       in_range;
`ifdef FRAME_PAINTER_OFFSCREEN_EN
    logic       offscreen_nxt;
`endif

    // Unsigned compare: negative snake coordinates arrive wrapped and land out of range.
    assign in_range = ({1'b0, rx} < X_LIM) && ({1'b0, ry} < Y_LIM);

    always_comb begin
        state_nxt      = state;
        pending_nxt    = pending;
        wd_nxt         = wd_cnt;
        cleared_nxt    = 1'b0;
        x_nxt          = vga_x;
        y_nxt          = vga_y;
        color_nxt      = vga_color;
        write_nxt      = 1'b0;
        frame_done_nxt = 1'b0;
        overrun_nxt    = 1'b0;
        timeout_nxt    = timeout;
`ifdef FRAME_PAINTER_OFFSCREEN_EN
        offscreen_nxt  = offscreen;
`endif

        if (busy && frame_tick) begin
            if (pending) begin
                overrun_nxt = 1'b1;
            end else begin
                pending_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (frame_tick || pending) begin
                    // first clear write (0,0) goes out on the same edge as the exit
                    state_nxt   = CLEAR;
                    pending_nxt = 1'b0;
                    timeout_nxt = 1'b0;
`ifdef FRAME_PAINTER_OFFSCREEN_EN
                    offscreen_nxt = 1'b0;
`endif
                    x_nxt       = 10'd0;
                    y_nxt       = 9'd0;
                    color_nxt   = BG_COLOR;
                    write_nxt   = 1'b1;
                end
            end
            CLEAR: begin
                // vga_x/vga_y double as the sweep counters
                if ((vga_x == X_LAST) && (vga_y == Y_LAST)) begin
                    state_nxt   = NOTIFY;
                    cleared_nxt = 1'b1;
                end else if (vga_x == X_LAST) begin
                    x_nxt     = 10'd0;
                    y_nxt     = vga_y + 9'd1;
                    color_nxt = BG_COLOR;
                    write_nxt = 1'b1;
                end else begin
                    x_nxt     = vga_x + 10'd1;
                    color_nxt = BG_COLOR;
                    write_nxt = 1'b1;
                end
            end
            NOTIFY: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                state_nxt = PAINT;
                wd_nxt    = WD_TC;
            end
            PAINT: begin
                if (write_done) begin
                    state_nxt      = DONE;
                    frame_done_nxt = 1'b1;
                end else if (wd_cnt == '0) begin
                    state_nxt      = DONE;
                    frame_done_nxt = 1'b1;
                    timeout_nxt    = 1'b1;
                end else begin
                    x_nxt     = rx;
                    y_nxt     = ry;
                    color_nxt = FG_COLOR;
                    write_nxt = in_range;
                    wd_nxt    = wd_cnt - WD_W'(1);
`ifdef FRAME_PAINTER_OFFSCREEN_EN
                    if (!in_range) begin
                        offscreen_nxt = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge draw_clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pending    <= 1'b0;
            wd_cnt     <= '0;
            cleared    <= 1'b0;
            vga_x      <= 10'd0;
            vga_y      <= 9'd0;
            vga_color  <= 3'd0;
            vga_write  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
`ifdef FRAME_PAINTER_OFFSCREEN_EN
            offscreen  <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            wd_cnt     <= wd_nxt;
            cleared    <= cleared_nxt;
            vga_x      <= x_nxt;
            vga_y      <= y_nxt;
            vga_color  <= color_nxt;
            vga_write  <= write_nxt;
            busy       <= busy_nxt;
            frame_done <= frame_done_nxt;
            overrun    <= overrun_nxt;
            timeout    <= timeout_nxt;
`ifdef FRAME_PAINTER_OFFSCREEN_EN
            offscreen  <= offscreen_nxt;
`endif
        end
    end

endmodule
